// File: rtl/instruction_fetch_queue_if.sv
// Bundle of fetch-side signals: instruction memory port, branch redirect,
// and the decode-facing valid/ready stream.
// The master modport is the fetch queue itself; the slave modport is the
// surrounding pipeline/memory.
interface instruction_fetch_queue_if #(
  parameter int DEPTH = 4
);
  logic [31:0]            imem_addr;
  logic [31:0]            imem_instr;
  logic                   branch_taken;
  logic [31:0]            branch_addr;
  logic                   out_valid;
  logic                   out_ready;
  logic [31:0]            out_instr;
  logic [31:0]            out_pc;
  logic [$clog2(DEPTH):0] count;

  modport master (
    output imem_addr, out_valid, out_instr, out_pc, count,
    input  imem_instr, branch_taken, branch_addr, out_ready
  );

  modport slave (
    input  imem_addr, out_valid, out_instr, out_pc, count,
    output imem_instr, branch_taken, branch_addr, out_ready
  );
endinterface

// File: rtl/instruction_fetch_queue.sv
// Instruction-fetch front end: owns the fetch PC, buffers each fetched word
// together with its PC+4 in a small prefetch FIFO, and lets a taken branch
// flush the FIFO and redirect fetch.
module instruction_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input logic                      clk,
  input logic                      rst,
  instruction_fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [31:0]   fpc_q, fpc_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [63:0]   mem_q [DEPTH];
  logic          push, pop;
  logic          not_empty;
  logic [63:0]   head;

  assign not_empty = (count_q != '0);
  assign head      = mem_q[rd_ptr_q];

  // Outputs: the fetch address is the PC register; the head reads as zero when empty.
  assign bus.imem_addr = fpc_q;
  assign bus.out_valid = not_empty;
  assign bus.out_instr = not_empty ? head[63:32] : 32'd0;
  assign bus.out_pc    = not_empty ? head[31:0]  : 32'd0;
  assign bus.count     = count_q;

  // Next-state: a branch flushes everything and voids any handshake; otherwise
  // push/pop update pointers, occupancy and the fetch PC (wrapping mod 2^32).
  always_comb begin
    fpc_d    = fpc_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    pop      = not_empty & bus.out_ready & ~bus.branch_taken;
    push     = ~bus.branch_taken & ((count_q < CW'(DEPTH)) | pop);
    if (bus.branch_taken) begin
      fpc_d    = {bus.branch_addr[31:2], 2'b00};
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + AW'(1);
        fpc_d    = fpc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  // State register with synchronous reset; reset overrides branch and handshakes.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc_q    <= RESET_PC;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      fpc_q    <= fpc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write: capture the fetched word and its return address; contents are not reset.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem_q[wr_ptr_q] <= {bus.imem_instr, fpc_q + 32'd4};
    end
  end
endmodule
